// File: rtl/sprite_pkg.sv
// Shared pixel types and helpers for the sprite renderer.
package sprite_pkg;

    typedef logic [11:0] rgb12_t;
    typedef logic [23:0] rgb24_t;

    localparam logic [7:0] TRANSP_DEFAULT = 8'hFF;

    // Keep the top nibble of each 8-bit channel.
    function automatic rgb12_t rgb24_to_12(input rgb24_t c);
        return {c[23:20], c[15:12], c[7:4]};
    endfunction

endpackage

// File: rtl/delay_line.sv
// Parametrised shift register used to align flags with external ROM latency.
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sprite_rom_renderer.sv
// ROM-backed sprite renderer: incremental address generation, power-of-two
// magnification, transparent index and frame-synchronous repositioning.
module sprite_rom_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned      WIDTH      = 437,
    parameter int unsigned      HEIGHT     = 277,
    parameter int unsigned      ADDR_W     = 17,
    parameter int unsigned      IDX_W      = 8,
    parameter int unsigned      HC_W       = 11,
    parameter int unsigned      VC_W       = 10,
    parameter int unsigned      X_INIT     = 112,
    parameter int unsigned      Y_INIT     = 112,
    parameter int unsigned      SCALE_LOG2 = 0,
    parameter int unsigned      ROM_LAT    = 2,
    parameter int unsigned      PAL_LAT    = 2,
    parameter int unsigned      TRANSP_EN  = 1,
    parameter logic [IDX_W-1:0] TRANSP_IDX = IDX_W'(TRANSP_DEFAULT)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    input  logic [HC_W-1:0]   hcount_in,
    input  logic [VC_W-1:0]   vcount_in,
    input  logic              pos_we_in,
    input  logic [HC_W-1:0]   x_pos_in,
    input  logic [VC_W-1:0]   y_pos_in,
    output logic              pos_pending_out,
    output logic [ADDR_W-1:0] rom_addr_out,
    input  logic [IDX_W-1:0]  rom_data_in,
    output logic [IDX_W-1:0]  pal_addr_out,
    input  logic [23:0]       pal_data_in,
    output logic [11:0]       pixel_out,
    output logic              hit_out
);

    localparam int unsigned SUB_W     = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam int unsigned SPR_W_I   = WIDTH << SCALE_LOG2;
    localparam int unsigned SPR_H_I   = HEIGHT << SCALE_LOG2;
    localparam int unsigned SUB_MAX_I = (1 << SCALE_LOG2) - 1;

    localparam logic [HC_W:0]     SPR_W    = SPR_W_I[HC_W:0];
    localparam logic [VC_W:0]     SPR_H    = SPR_H_I[VC_W:0];
    localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_MAX_I[SUB_W-1:0];
    localparam logic [ADDR_W-1:0] ROW_STEP = WIDTH[ADDR_W-1:0];
    localparam logic [HC_W-1:0]   X0       = X_INIT[HC_W-1:0];
    localparam logic [VC_W-1:0]   Y0       = Y_INIT[VC_W-1:0];

    logic [HC_W-1:0]   x_q, pend_x_q;
    logic [VC_W-1:0]   y_q, pend_y_q, prev_vcount_q;
    logic              pending_q, armed_q, prev_vwin_q;
    logic [ADDR_W-1:0] row_base_q, col_q;
    logic [SUB_W-1:0]  hsub_q, vsub_q;

    logic [HC_W:0] hc_ext, x_ext;
    logic [VC_W:0] vc_ext, y_ext;
    logic          hwin, vwin, win, frame_start, line_change;

    // Extra top bit keeps x+width from wrapping: an overflowing sprite clips.
    assign hc_ext      = {1'b0, hcount_in};
    assign x_ext       = {1'b0, x_q};
    assign vc_ext      = {1'b0, vcount_in};
    assign y_ext       = {1'b0, y_q};
    assign hwin        = (hc_ext >= x_ext) && (hc_ext < x_ext + SPR_W);
    assign vwin        = (vc_ext >= y_ext) && (vc_ext < y_ext + SPR_H);
    assign win         = armed_q && hwin && vwin;
    assign frame_start = (hcount_in == '0) && (vcount_in == '0);
    assign line_change = (vcount_in != prev_vcount_q);

    assign rom_addr_out    = win ? row_base_q + col_q : row_base_q;
    assign pal_addr_out    = rom_data_in;
    assign pos_pending_out = pending_q;

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            x_q           <= X0;
            y_q           <= Y0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            pending_q     <= 1'b0;
            armed_q       <= 1'b0;
            row_base_q    <= '0;
            col_q         <= '0;
            hsub_q        <= '0;
            vsub_q        <= '0;
            prev_vcount_q <= '0;
            prev_vwin_q   <= 1'b0;
        end else begin
            prev_vcount_q <= vcount_in;
            prev_vwin_q   <= vwin;
            if (frame_start) begin
                armed_q    <= 1'b1;
                row_base_q <= '0;
                col_q      <= '0;
                hsub_q     <= '0;
                vsub_q     <= '0;
                if (pos_we_in) begin
                    x_q       <= x_pos_in;
                    y_q       <= y_pos_in;
                    pending_q <= 1'b0;
                end else if (pending_q) begin
                    x_q       <= pend_x_q;
                    y_q       <= pend_y_q;
                    pending_q <= 1'b0;
                end
            end else begin
                if (pos_we_in) begin
                    pend_x_q  <= x_pos_in;
                    pend_y_q  <= y_pos_in;
                    pending_q <= 1'b1;
                end
                if (win) begin
                    if (hsub_q == SUB_MAX) begin
                        hsub_q <= '0;
                        col_q  <= col_q + 1'b1;
                    end else begin
                        hsub_q <= hsub_q + 1'b1;
                    end
                end else if (!hwin) begin
                    hsub_q <= '0;
                    col_q  <= '0;
                end
                // Row advance keys off the line change, not the right edge,
                // so horizontally clipped rows still step row_base.
                if (line_change && prev_vwin_q) begin
                    if (vsub_q == SUB_MAX) begin
                        vsub_q     <= '0;
                        row_base_q <= row_base_q + ROW_STEP;
                    end else begin
                        vsub_q <= vsub_q + 1'b1;
                    end
                end
            end
        end
    end

    logic       win_rom, transp, hit;
    logic [1:0] pal_flags;

    assign transp = (TRANSP_EN != 0) && (rom_data_in == TRANSP_IDX);

    delay_line #(.WIDTH(1), .DEPTH(ROM_LAT)) u_rom_align (
        .clk   (pixel_clk_in),
        .rst_n (rst_n_in),
        .din   (win),
        .dout  (win_rom)
    );

    delay_line #(.WIDTH(2), .DEPTH(PAL_LAT)) u_pal_align (
        .clk   (pixel_clk_in),
        .rst_n (rst_n_in),
        .din   ({win_rom, transp}),
        .dout  (pal_flags)
    );

    assign hit = pal_flags[1] && !pal_flags[0];

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            hit_out   <= 1'b0;
            pixel_out <= '0;
        end else begin
            hit_out   <= hit;
            pixel_out <= hit ? rgb24_to_12(pal_data_in) : '0;
        end
    end

endmodule

// File: tb/tb_sprite_rom_renderer.sv
// Self-checking bench: two renderer instances (1x with transparency, 2x without)
// on a small raster, checked against a coordinate-based reference model.
module tb_sprite_rom_renderer;

    localparam int W     = 9;
    localparam int H     = 4;
    localparam int XI    = 5;
    localparam int YI    = 3;
    localparam int L     = 5;
    localparam int H_TOT = 32;
    localparam int V_TOT = 12;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, we;
    logic [4:0]  hc, xp;
    logic [3:0]  vc, yp;
    logic        pend_a, pend_b, hit_a, hit_b;
    logic [7:0]  addr_a, addr_b, rd_a, rd_b, pa_a, pa_b;
    logic [23:0] pd_a, pd_b;
    logic [11:0] pix_a, pix_b;

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return (a == 8'd5) ? 8'hFF : a;
    endfunction

    function automatic logic [23:0] pal_f(input logic [7:0] i);
        return {i, i ^ 8'h5A, ~i};
    endfunction

    function automatic logic [11:0] px12(input logic [23:0] c);
        return {c[23:20], c[15:12], c[7:4]};
    endfunction

    sprite_rom_renderer #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(8), .IDX_W(8), .HC_W(5), .VC_W(4),
        .X_INIT(XI), .Y_INIT(YI), .SCALE_LOG2(0), .ROM_LAT(2), .PAL_LAT(2),
        .TRANSP_EN(1), .TRANSP_IDX(8'hFF)
    ) dut_a (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .pos_we_in(we), .x_pos_in(xp), .y_pos_in(yp), .pos_pending_out(pend_a),
        .rom_addr_out(addr_a), .rom_data_in(rd_a), .pal_addr_out(pa_a),
        .pal_data_in(pd_a), .pixel_out(pix_a), .hit_out(hit_a)
    );

    sprite_rom_renderer #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(8), .IDX_W(8), .HC_W(5), .VC_W(4),
        .X_INIT(XI), .Y_INIT(YI), .SCALE_LOG2(1), .ROM_LAT(2), .PAL_LAT(2),
        .TRANSP_EN(0), .TRANSP_IDX(8'hFF)
    ) dut_b (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .pos_we_in(we), .x_pos_in(xp), .y_pos_in(yp), .pos_pending_out(pend_b),
        .rom_addr_out(addr_b), .rom_data_in(rd_b), .pal_addr_out(pa_b),
        .pal_data_in(pd_b), .pixel_out(pix_b), .hit_out(hit_b)
    );

    // External ROMs: two-cycle read latency each
    logic [7:0] ra_a1, ra_a2, ra_b1, ra_b2, qa_a1, qa_a2, qa_b1, qa_b2;
    always @(posedge clk) begin
        ra_a1 <= addr_a; ra_a2 <= ra_a1;
        ra_b1 <= addr_b; ra_b2 <= ra_b1;
        qa_a1 <= pa_a;   qa_a2 <= qa_a1;
        qa_b1 <= pa_b;   qa_b2 <= qa_b1;
    end
    assign rd_a = rom_f(ra_a2);
    assign rd_b = rom_f(ra_b2);
    assign pd_a = pal_f(qa_a2);
    assign pd_b = pal_f(qa_b2);

    typedef struct packed {
        logic        ha;
        logic [11:0] pa;
        logic        hb;
        logic [11:0] pb;
    } exp_t;
    exp_t q[$];

    typedef struct {
        int h;
        int v;
        int addr_a;
        int addr_b;
    } vec_t;
    vec_t vecs[12];

    int n_cmp = 0, n_bad = 0;
    int h, v, fnum, nstep = 0;
    int m_x, m_y, m_px, m_py;
    bit m_armed, m_pend;
    int hits_a = 0, hits_b = 0, post_rst_hits = 0;
    bit in_post_rst = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at h=%0d v=%0d frame=%0d: got %0h, expected %0h",
                     name, h, v, fnum, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit w, input int nx, input int ny);
        exp_t e, o;
        bit   wa, wb;
        int   aa, ab;
        @(posedge clk);
        #1;
        if (q.size() >= L) begin
            o = q.pop_front();
            chk("hit_a", hit_a, o.ha);
            chk("pixel_a", pix_a, o.pa);
            chk("hit_b", hit_b, o.hb);
            chk("pixel_b", pix_b, o.pb);
            hits_a += int'(hit_a);
            hits_b += int'(hit_b);
            if (in_post_rst) post_rst_hits += int'(hit_a) + int'(hit_b);
        end
        if (nstep > 0) begin
            chk("pending_a", pend_a, m_pend);
            chk("pending_b", pend_b, m_pend);
        end
        nstep++;
        rst_n = r;
        hc    = h[4:0];
        vc    = v[3:0];
        we    = w;
        xp    = nx[4:0];
        yp    = ny[3:0];
        #1;
        wa = m_armed && h >= m_x && h < m_x + W     && v >= m_y && v < m_y + H;
        wb = m_armed && h >= m_x && h < m_x + 2 * W && v >= m_y && v < m_y + 2 * H;
        aa = (v - m_y) * W + (h - m_x);
        ab = ((v - m_y) / 2) * W + (h - m_x) / 2;
        e  = '0;
        if (r) begin
            if (wa) begin
                chk("addr_a", addr_a, aa);
                e.ha = (rom_f(aa[7:0]) != 8'hFF);
                if (e.ha) e.pa = px12(pal_f(rom_f(aa[7:0])));
            end
            if (wb) begin
                chk("addr_b", addr_b, ab);
                e.hb = 1'b1;
                e.pb = px12(pal_f(rom_f(ab[7:0])));
            end
            if (fnum == 1) begin
                for (int i = 0; i < 12; i++) begin
                    if (vecs[i].h == h && vecs[i].v == v) begin
                        chk("vec_addr_a", addr_a, vecs[i].addr_a);
                        chk("vec_addr_b", addr_b, vecs[i].addr_b);
                    end
                end
            end
        end else begin
            q.delete();
            repeat (L - 1) q.push_back('0);
        end
        q.push_back(e);

        if (!r) begin
            m_armed = 0; m_x = XI; m_y = YI; m_pend = 0;
        end else if (h == 0 && v == 0) begin
            m_armed = 1;
            if (w) begin
                m_x = nx; m_y = ny; m_pend = 0;
            end else if (m_pend) begin
                m_x = m_px; m_y = m_py; m_pend = 0;
            end
        end else if (w) begin
            m_px = nx; m_py = ny; m_pend = 1;
        end

        h++;
        if (h == H_TOT) begin
            h = 0;
            v = (v == V_TOT - 1) ? 0 : v + 1;
        end
    endtask

    initial begin
        // {h, v, addr_a, addr_b}: first armed frame at (5,3); off-window = row base
        vecs[0]  = '{5, 3, 0, 0};
        vecs[1]  = '{6, 3, 1, 0};
        vecs[2]  = '{7, 3, 2, 1};
        vecs[3]  = '{8, 3, 3, 1};
        vecs[4]  = '{5, 4, 9, 0};
        vecs[5]  = '{13, 4, 17, 4};
        vecs[6]  = '{5, 5, 18, 9};
        vecs[7]  = '{6, 6, 28, 9};
        vecs[8]  = '{14, 7, 36, 22};
        vecs[9]  = '{22, 10, 36, 35};
        vecs[10] = '{23, 3, 0, 0};
        vecs[11] = '{2, 5, 18, 9};

        rst_n = 1'b0; we = 1'b0; hc = '0; vc = '0; xp = '0; yp = '0;
        h = 10; v = 3; fnum = 0;
        m_x = XI; m_y = YI; m_px = 0; m_py = 0; m_armed = 0; m_pend = 0;

        for (int c = 0; c < 6000 && fnum < 12; c++) begin
            bit r, w;
            int nx, ny;
            r = 1; w = 0; nx = 0; ny = 0;
            if (h == 0 && v == 0) fnum++;
            if (fnum == 5 && in_post_rst) begin
                in_post_rst = 0;
                chk("post_reset_hits", post_rst_hits, 0);
            end
            if (c < 3) r = 0;
            else if (fnum == 2 && h == 7 && v == 4) begin w = 1; nx = 20; ny = 1; end
            else if (fnum == 2 && h == 9 && v == 9) begin w = 1; nx = 22; ny = 2; end
            else if (fnum == 3 && h == 0 && v == 0) begin w = 1; nx = 25; ny = 5; end
            else if (fnum == 3 && h == 3 && v == 6) begin w = 1; nx = 12; ny = 0; end
            else if (fnum == 4 && h == 15 && v == 2) r = 0;
            else if (fnum >= 5 && $urandom_range(0, 149) == 0) begin
                w  = 1;
                nx = int'($urandom_range(1, 31));
                ny = int'($urandom_range(0, 11));
            end
            step(r, w, nx, ny);
            if (fnum == 4 && !r) in_post_rst = 1;
        end
        if (fnum < 12) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cycle_budget: reached frame %0d, required 12", fnum);
        end
        chk("hits_a_seen", hits_a != 0, 1);
        chk("hits_b_seen", hits_b != 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_rom_renderer.md
Name: sprite_rom_renderer

Overview:
Parametrised ROM-backed sprite renderer for the VGA pixel pipeline; the next generation of the static table/background image block. It generates the image ROM address incrementally rather than by multiply, and supports power-of-two magnification, a transparent palette index and a runtime-movable position applied only at frame start (tear-free). It also aligns the in-window flag to a configurable ROM and palette latency. The image ROM and palette ROM are external; the block drives their addresses and consumes their data.

Parameters:
WIDTH, 437, source image width in pixels
HEIGHT, 277, source image height in pixels
ADDR_W, 17, image ROM address width (must hold WIDTH*HEIGHT-1)
IDX_W, 8, palette index width
HC_W, 11, hcount width
VC_W, 10, vcount width
X_INIT, 112, reset x position
Y_INIT, 112, reset y position
SCALE_LOG2, 0, magnification exponent; each source pixel drawn 2^SCALE_LOG2 x 2^SCALE_LOG2
ROM_LAT, 2, image ROM read latency in cycles
PAL_LAT, 2, palette ROM read latency in cycles
TRANSP_EN, 1, enable transparent index
TRANSP_IDX, 8'hFF, index treated as transparent

Ports:
pixel_clk_in  in  1  pixel clock
rst_n_in  in  1  synchronous active-low reset
hcount_in  in  HC_W  current x; increments by 1 per cycle within a line
vcount_in  in  VC_W  current y
pos_we_in  in  1  position write strobe
x_pos_in  in  HC_W  new x position
y_pos_in  in  VC_W  new y position
pos_pending_out  out  1  written position not yet applied
rom_addr_out  out  ADDR_W  image ROM address
rom_data_in  in  IDX_W  palette index, valid ROM_LAT cycles after address
pal_addr_out  out  IDX_W  palette address (= rom_data_in, combinational)
pal_data_in  in  24  {r8,g8,b8}, valid PAL_LAT cycles after pal_addr_out
pixel_out  out  12  {r[7:4],g[7:4],b[7:4]}; 0 when no hit
hit_out  out  1  opaque sprite pixel present

Behaviour:
- Clocking: single clock pixel_clk_in. rst_n_in is synchronous, active-low, sampled on the rising edge.
- Reset: x,y <= X_INIT,Y_INIT; pending <= 0; row_base, col, hsub, vsub <= 0; all delay-line flags <= 0; pixel_out <= 0; hit_out <= 0; armed <= 0.
- Armed flag: rendering is suppressed (in-window forced 0) until the first frame start after reset. This covers reset mid-frame.
- Frame start: the cycle where hcount_in==0 and vcount_in==0. On it: armed <= 1; row_base, vsub, col, hsub <= 0; if pending, x,y <= pending values and pending <= 0.
- Simultaneous pos_we_in with frame start: the new values are applied immediately and pending stays 0. Any later write before the next frame start overwrites the pending values.
- Window: hwin = hcount_in in [x, x+(WIDTH<<S)); vwin = vcount_in in [y, y+(HEIGHT<<S)); win = armed & hwin & vwin. All comparisons are at HC_W+1 / VC_W+1 bits, so x+width overflow clips and never wraps.
- Address: rom_addr_out = row_base + col (combinational from state) whenever win, else row_base.
  - In win, hsub increments each cycle; at hsub == 2^S-1 it wraps to 0 and col increments.
  - Outside hwin: col <= 0, hsub <= 0.
- Row advance: triggered on any vcount_in change where the previous line was inside vwin. vsub increments; at wrap, row_base += WIDTH. This is independent of the right screen edge, so horizontal clipping is safe.
- Latency: L = ROM_LAT + PAL_LAT + 1. pixel_out and hit_out at cycle t+L correspond to hcount_in/vcount_in at cycle t.
  - win is delayed ROM_LAT cycles, sampled alongside rom_data_in.
  - The transparent test (TRANSP_EN && rom_data_in==TRANSP_IDX) is taken at that point.
  - Both flags are delayed a further PAL_LAT cycles.
  - Output register: hit_out <= win_d & ~transp_d; pixel_out <= hit ? truncated pal_data_in : 0.
- pos_pending_out: high from the cycle after an accepted write until the cycle after it is applied.

Decomposition:
- Package sprite_pkg: rgb12_t, rgb24_t, function rgb24_to_12, TRANSP_DEFAULT constant.
- One sub-module: delay_line (parametrised WIDTH and DEPTH shift register with synchronous active-low reset, DEPTH 0 = wire). Instantiated twice, for the ROM_LAT and PAL_LAT alignment.

Test Plan:
1. Reset then raster from (0,0), defaults, ROM model returning addr[7:0]. At hcount=112, vcount=112 -> rom_addr_out=0. At hcount=113 -> 1. At next line hcount=112 -> 437. pixel/hit asserted exactly 5 cycles later.
2. SCALE_LOG2=1. At vcount=112: hcount 112,113 -> addr 0; 114,115 -> addr 1. Line 113 repeats addr 0. Line 114 starts at addr 437.
3. ROM returns 8'hFF at addr 5 -> hit_out=0 and pixel_out=0 for that pixel only. With TRANSP_EN=0 the same pixel is drawn.
4. pos_we_in mid-frame with (200,50) -> pos_pending_out=1; current frame still drawn at 112,112. At the next (0,0), pending clears and the window starts at hcount=200, vcount=50.
5. x_pos=1000 (sprite clipped at right edge, hcount max 1023) -> row_base still advances by 437 per line. No address corruption on line y+1.
6. Assert rst_n_in mid-window -> next cycle pixel_out=0, hit_out=0. No hits until the next (0,0). Afterwards the first window address is 0.
